serial_word_fifo: RTL and testbench
===================================

Name: serial_word_fifo

Overview:
- Parametrised successor to the bit-serial byte queue.
- Deserialises a bit stream on `data_in`, MSB first, into `DATA_W`-bit words while `write_in` is high, and pushes each completed word into a `DEPTH`-entry circular FIFO.
- Each rising edge of `dequeue_in` pops one word to `data_out`.
- Runs from the single `clock1M` domain using an internal bit-timing prescaler (no derived clocks), and adds occupancy plus sticky overflow/underflow reporting.

Parameters:
- DATA_W, 8: word width in bits; must be >= 2.
- DEPTH, 8: FIFO entries; must be >= 2; any value (not restricted to powers of two).
- BIT_TICKS, 10: clock cycles per serial bit; must be >= 2.
- CNT_W (localparam) = $clog2(DEPTH+1): width of `count_out`.

Ports:
- clock1M, input, 1: system clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-low reset; sampled on the rising edge of `clock1M`.
- data_in, input, 1: serial data bit, MSB first.
- write_in, input, 1: frame enable; high for the duration of one word (`DATA_W`*`BIT_TICKS` cycles).
- dequeue_in, input, 1: pop request; level input, rising edge pops exactly one word.
- clear_flags, input, 1: synchronous clear of the overflow and underflow flags.
- data_out, output, DATA_W: last popped word, registered.
- status_out, output, 1: FIFO full (count == DEPTH).
- empty_out, output, 1: count == 0.
- count_out, output, CNT_W: current occupancy, 0..DEPTH.
- overflow_out, output, 1: sticky; set when a completed word is dropped.
- underflow_out, output, 1: sticky; set when a pop hits an empty FIFO.

Behaviour:
- Reset (`reset` == 0 at a clock edge):
  - Prescaler, bit counter, shift register, pointers, count and `dequeue_q` all go to 0.
  - Outputs: `data_out` = 0, `status_out` = 0, `empty_out` = 1, `count_out` = 0, `overflow_out` = 0, `underflow_out` = 0.
  - Memory contents are don't-care.
  - Reset mid-word discards the partial word; reset overrides every other event in that cycle.
- Bit timing:
  - The prescaler `tick` counts 0..BIT_TICKS-1 while `write_in` = 1, then wraps.
  - When `write_in` = 0, `tick` and `bitcnt` are forced to 0 and any partial word is discarded.
  - A sample is taken on the edge where `tick` == BIT_TICKS/2 (integer division): `shift <= {shift[DATA_W-2:0], data_in}` and `bitcnt` increments.
- Word completion:
  - Occurs on the sample edge where `bitcnt` == DATA_W-1.
  - The word is `{shift[DATA_W-2:0], data_in}`; `bitcnt` returns to 0.
  - The word is pushed on that same edge if the push is allowed (see Push/pop arbitration).
  - If `write_in` stays high, the next word starts immediately (back-to-back frames).
- Pop:
  - `dequeue_q` registers `dequeue_in` each cycle; `pop_req = dequeue_in & ~dequeue_q`.
  - If count > 0: `data_out <= mem[rd_ptr]` on that edge, and `rd_ptr` advances.
  - If count == 0: `underflow_out <= 1`, and `data_out` and the pointers are unchanged.
  - Holding `dequeue_in` high pops only once.
- Push/pop arbitration within a cycle:
  - A pop is accepted iff count > 0.
  - A push is accepted iff count < DEPTH, or a pop is accepted in the same cycle.
  - If full and a word completes with no pop that cycle: the word is dropped and `overflow_out <= 1`.
  - If empty and both push and pop occur: the push is accepted, the pop underflows, and `data_out` does not receive the new word.
  - count_next = count + push_acc - pop_acc.
- Pointers: `wr_ptr` and `rd_ptr` each wrap from DEPTH-1 to 0 via explicit compare.
- Output timing: `status_out`, `empty_out` and `count_out` are registered (or decoded from the registered count) and reflect the update one edge after the event.
- `clear_flags`:
  - Clears `overflow_out` and `underflow_out` on the next edge.
  - A set event in the same cycle wins, so the flag stays 1.

Test Plan (DATA_W=8, DEPTH=8, BIT_TICKS=10):
- Four frames, each `write_in`=1 for 80 cycles and 20 idle cycles between frames, bits 0xAA, 0xCC, 0xF0, 0x0F; then 4 dequeue pulses of 100 cycles with 20-cycle gaps -> `count_out` goes 1..4 then back to 0; `data_out` = 0xAA, 0xCC, 0xF0, 0x0F, each seen once per pulse; `empty_out`=1 at the end.
- Frames 0x33, 0x55, 0x99, 0xFF, 0x01..0x04 followed by a ninth frame 0x00 -> `status_out`=1, `count_out`=8, `overflow_out`=1; 8 pops return 0x33, 0x55, 0x99, 0xFF, 0x01, 0x02, 0x03, 0x04, which exercises pointer wrap.
- Ninth pop on the empty FIFO -> `underflow_out`=1 and `data_out` stays 0x04; then pulse `clear_flags` -> both flags 0.
- `write_in` dropped after 3 sampled bits, then a full frame 0x5A -> only 0x5A is enqueued and `count_out`=1.
- FIFO full, with a `dequeue_in` rising edge aligned to the completion edge of frame 0xC3 -> `count_out` stays 8, no overflow, and 0xC3 is the last word popped.
- Reset asserted for 1 cycle mid-frame after 5 bits with 3 words queued -> all outputs return to their reset values; the next full frame 0x81 pops as 0x81.

Source files
------------

// File: rtl/serial_word_fifo.sv
// Bit-serial (MSB first) to word deserialiser feeding a circular FIFO,
// with occupancy and sticky overflow/underflow reporting.
module serial_word_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int BIT_TICKS = 10,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clock1M,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              dequeue_in,
    input  logic              clear_flags,
    output logic [DATA_W-1:0] data_out,
    output logic              status_out,
    output logic              empty_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    localparam int TICK_W = $clog2(BIT_TICKS);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(BIT_TICKS / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_deq_q;
    logic              r_ovf;
    logic              r_udf;

    logic              w_sample;
    logic              w_done;
    logic [DATA_W-1:0] w_word;
    logic              w_pop_req;
    logic              w_pop_acc;
    logic              w_push_acc;

    assign w_sample   = write_in && (r_tick == TICK_MID);
    assign w_done     = w_sample && (r_bitcnt == BIT_LAST);
    assign w_word     = {r_shift[DATA_W-2:0], data_in};
    assign w_pop_req  = dequeue_in && !r_deq_q;
    assign w_pop_acc  = w_pop_req && (r_count != '0);
    // A full FIFO still takes the word when a pop frees a slot this cycle
    assign w_push_acc = w_done && ((r_count != CNT_FULL) || w_pop_acc);

    always_ff @(posedge clock1M) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_deq_q  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_deq_q <= dequeue_in;

            if (!write_in) begin
                r_tick   <= '0;
                r_bitcnt <= '0;
            end else begin
                r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
                if (w_sample) begin
                    r_shift  <= w_word;
                    r_bitcnt <= w_done ? '0 : r_bitcnt + 1'b1;
                end
            end

            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end

            if (w_pop_acc) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end

            r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);

            // Set events take priority over a simultaneous clear
            if (w_done && !w_push_acc) begin
                r_ovf <= 1'b1;
            end else if (clear_flags) begin
                r_ovf <= 1'b0;
            end

            if (w_pop_req && (r_count == '0)) begin
                r_udf <= 1'b1;
            end else if (clear_flags) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign data_out      = r_data;
    assign status_out    = (r_count == CNT_FULL);
    assign empty_out     = (r_count == '0);
    assign count_out     = r_count;
    assign overflow_out  = r_ovf;
    assign underflow_out = r_udf;

endmodule

// File: tb/tb_serial_word_fifo.sv
// Scoreboard bench for serial_word_fifo: stimulus queues expected pop
// results, a monitor checks data_out after every dequeue rising edge.
module tb_serial_word_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       wr;
    logic       deq;
    logic       clr;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [3:0] cnt;
    logic       ovf;
    logic       udf;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb [$];
    logic       mon_q  = 1'b0;
    logic       mon_ev = 1'b0;

    serial_word_fifo #(
        .DATA_W   (8),
        .DEPTH    (8),
        .BIT_TICKS(10)
    ) dut (
        .clock1M      (clk),
        .reset        (rst_n),
        .data_in      (din),
        .write_in     (wr),
        .dequeue_in   (deq),
        .clear_flags  (clr),
        .data_out     (dout),
        .status_out   (full),
        .empty_out    (empty),
        .count_out    (cnt),
        .overflow_out (ovf),
        .underflow_out(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Pop-edge detector derived from the stimulus itself
    always @(posedge clk) begin
        mon_ev = rst_n && deq && !mon_q;
        mon_q  = rst_n ? deq : 1'b0;
    end

    always @(negedge clk) begin
        if (mon_ev) begin
            mon_ev = 1'b0;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got %0h expected none", dout);
            end else begin
                check("pop_data", int'(dout), int'(sb.pop_front()));
            end
        end
    end

    // Drive a frame of len cycles; optionally pop or reset at a cycle index
    task automatic frame(input logic [7:0] w, input int len,
                         input int pop_at, input int rst_at);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                rst_n = 1'b1;
                wr    = 1'b0;
                din   = 1'b0;
                return;
            end
            wr  = 1'b1;
            din = w[7 - i / 10];
            if (i == pop_at) deq = 1'b1;
        end
        @(negedge clk);
        wr  = 1'b0;
        din = 1'b0;
        deq = 1'b0;
        repeat (19) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w);
        frame(w, 80, -1, -1);
    endtask

    task automatic pop(input logic [7:0] exp);
        sb.push_back(exp);
        @(negedge clk);
        deq = 1'b1;
        repeat (100) @(negedge clk);
        deq = 1'b0;
        repeat (19) @(negedge clk);
    endtask

    logic [7:0] t1 [4] = '{8'hAA, 8'hCC, 8'hF0, 8'h0F};
    logic [7:0] t2 [8] = '{8'h33, 8'h55, 8'h99, 8'hFF,
                           8'h01, 8'h02, 8'h03, 8'h04};

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        wr    = 1'b0;
        deq   = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(dout), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(cnt), 0);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_udf", int'(udf), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send(t1[i]);
            check("t1_count_up", int'(cnt), i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            pop(t1[i]);
            check("t1_count_dn", int'(cnt), 3 - i);
        end
        check("t1_empty", int'(empty), 1);

        for (int i = 0; i < 8; i++) send(t2[i]);
        check("t2_full", int'(full), 1);
        check("t2_ovf_pre", int'(ovf), 0);
        send(8'h00);
        check("t2_count", int'(cnt), 8);
        check("t2_ovf", int'(ovf), 1);
        for (int i = 0; i < 8; i++) pop(t2[i]);
        check("t2_empty", int'(empty), 1);

        pop(8'h04);
        check("t3_udf", int'(udf), 1);
        check("t3_ovf_held", int'(ovf), 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_clr_ovf", int'(ovf), 0);
        check("t3_clr_udf", int'(udf), 0);

        frame(8'hE0, 35, -1, -1);
        send(8'h5A);
        check("t4_count", int'(cnt), 1);

        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i));
        check("t5_full", int'(full), 1);
        sb.push_back(8'h5A);
        frame(8'hC3, 80, 75, -1);
        check("t5_count", int'(cnt), 8);
        check("t5_ovf", int'(ovf), 0);
        for (int i = 0; i < 7; i++) pop(8'h10 + 8'(i));
        pop(8'hC3);
        check("t5_empty", int'(empty), 1);

        send(8'h21);
        send(8'h22);
        send(8'h23);
        check("t6_count_pre", int'(cnt), 3);
        frame(8'hB7, 80, -1, 50);
        check("t6_rst_data", int'(dout), 0);
        check("t6_rst_count", int'(cnt), 0);
        check("t6_rst_empty", int'(empty), 1);
        check("t6_rst_full", int'(full), 0);
        check("t6_rst_ovf", int'(ovf), 0);
        check("t6_rst_udf", int'(udf), 0);
        repeat (20) @(negedge clk);
        send(8'h81);
        check("t6_count", int'(cnt), 1);
        pop(8'h81);
        check("t6_empty", int'(empty), 1);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
